// File: rtl/routine_bus_pkg.sv
// Shared field map, widths and state encoding for the routine bus sequencer.
// Every routine block drives the same 47-bit bus layout described here.
package routine_bus_pkg;

    localparam int BUS_W      = 47;
    localparam int LED_W      = 18;
    localparam int HEX_W      = 7;
    localparam int NUM_SLOTS  = 4;
    localparam int CNT_W      = 8;

    localparam int SIGOUT_BIT = 46;
    localparam int LED_HI     = 45;
    localparam int LED_LO     = 28;
    localparam int HEX3_HI    = 27;
    localparam int HEX3_LO    = 21;
    localparam int HEX2_HI    = 20;
    localparam int HEX2_LO    = 14;
    localparam int HEX1_HI    = 13;
    localparam int HEX1_LO    = 7;
    localparam int HEX0_HI    = 6;
    localparam int HEX0_LO    = 0;

    localparam logic [HEX_W-1:0] HEX_BLANK = 7'h7F;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        BLANK = 2'd1,
        RUN   = 2'd2
    } seq_state_t;

    // Only the selected routine is released from reset.
    function automatic logic [NUM_SLOTS-1:0] run_reset(
        input logic [1:0] sel
    );
        logic [NUM_SLOTS-1:0] mask;
        mask = '1;
        mask[sel] = 1'b0;
        return mask;
    endfunction

endpackage

// File: rtl/routine_bus_unpack.sv
// Combinational split of one routine bus into its done flag,
// LED field and four seven-segment fields.
module routine_bus_unpack
    import routine_bus_pkg::*;
(
    input  logic [BUS_W-1:0] bus,
    output logic             done,
    output logic [LED_W-1:0] led,
    output logic [HEX_W-1:0] hex3,
    output logic [HEX_W-1:0] hex2,
    output logic [HEX_W-1:0] hex1,
    output logic [HEX_W-1:0] hex0
);

    assign done = bus[SIGOUT_BIT];
    assign led  = bus[LED_HI:LED_LO];
    assign hex3 = bus[HEX3_HI:HEX3_LO];
    assign hex2 = bus[HEX2_HI:HEX2_LO];
    assign hex1 = bus[HEX1_HI:HEX1_LO];
    assign hex0 = bus[HEX0_HI:HEX0_LO];

endmodule

// File: rtl/routine_bus_sequencer.sv
// Rotates through the routine buses, counting done pulses per routine,
// blanking the display between routines and holding idle ones in reset.
module routine_bus_sequencer
    import routine_bus_pkg::*;
#(
    parameter int NUM_ROUTINES = 4,
    parameter int REPEATS      = 2,
    parameter int BLANK_CYCLES = 4
) (
    input  logic                 Clock,
    input  logic                 Reset,
    input  logic                 Enable,
    input  logic                 Advance,
    input  logic [BUS_W-1:0]     RoutineBus0,
    input  logic [BUS_W-1:0]     RoutineBus1,
    input  logic [BUS_W-1:0]     RoutineBus2,
    input  logic [BUS_W-1:0]     RoutineBus3,
    output logic [NUM_SLOTS-1:0] RoutineReset,
    output logic [1:0]           RoutineSel,
    output logic [LED_W-1:0]     LedOut,
    output logic [HEX_W-1:0]     Hex3,
    output logic [HEX_W-1:0]     Hex2,
    output logic [HEX_W-1:0]     Hex1,
    output logic [HEX_W-1:0]     Hex0,
    output logic                 SwitchPulse
);

    localparam logic [1:0]       LAST_SEL = 2'(NUM_ROUTINES - 1);
    localparam logic [CNT_W-1:0] REP_TC   = CNT_W'(REPEATS);
    localparam logic [CNT_W-1:0] BLK_TC   = CNT_W'(BLANK_CYCLES - 1);

    seq_state_t       state;
    logic [CNT_W-1:0] rep_cnt;
    logic [CNT_W-1:0] blk_cnt;
    logic             done_q;

    logic [BUS_W-1:0] mux_bus;
    logic             sel_done;
    logic [LED_W-1:0] sel_led;
    logic [HEX_W-1:0] sel_hex3;
    logic [HEX_W-1:0] sel_hex2;
    logic [HEX_W-1:0] sel_hex1;
    logic [HEX_W-1:0] sel_hex0;

    logic             done_edge;
    logic [CNT_W-1:0] rep_next;
    logic             go_next;
    logic [1:0]       next_sel;

    // Unpopulated slots read as an all-zero bus.
    always_comb begin
        mux_bus = '0;
        case (RoutineSel)
            2'd0: mux_bus = RoutineBus0;
            2'd1: if (NUM_ROUTINES > 1) mux_bus = RoutineBus1;
            2'd2: if (NUM_ROUTINES > 2) mux_bus = RoutineBus2;
            2'd3: if (NUM_ROUTINES > 3) mux_bus = RoutineBus3;
            default: mux_bus = '0;
        endcase
    end

    routine_bus_unpack u_unpack (
        .bus  (mux_bus),
        .done (sel_done),
        .led  (sel_led),
        .hex3 (sel_hex3),
        .hex2 (sel_hex2),
        .hex1 (sel_hex1),
        .hex0 (sel_hex0)
    );

    always_comb begin
        done_edge = sel_done & ~done_q;
        rep_next  = rep_cnt + CNT_W'(1);
        go_next   = Advance | (done_edge & (rep_next == REP_TC));
        next_sel  = (RoutineSel == LAST_SEL) ? 2'd0 : RoutineSel + 2'd1;
    end

    always_ff @(posedge Clock) begin
        if (Reset) begin
            state        <= IDLE;
            RoutineSel   <= 2'd0;
            RoutineReset <= '1;
            LedOut       <= '0;
            Hex3         <= HEX_BLANK;
            Hex2         <= HEX_BLANK;
            Hex1         <= HEX_BLANK;
            Hex0         <= HEX_BLANK;
            SwitchPulse  <= 1'b0;
            rep_cnt      <= '0;
            blk_cnt      <= '0;
            done_q       <= 1'b0;
        end else begin
            // Blank, all-in-reset outputs unless RUN overrides below.
            SwitchPulse  <= 1'b0;
            RoutineReset <= '1;
            LedOut       <= '0;
            Hex3         <= HEX_BLANK;
            Hex2         <= HEX_BLANK;
            Hex1         <= HEX_BLANK;
            Hex0         <= HEX_BLANK;
            if (!Enable) begin
                state   <= IDLE;
                rep_cnt <= '0;
                blk_cnt <= '0;
                done_q  <= 1'b0;
            end else begin
                unique case (state)
                    IDLE: begin
                        state   <= BLANK;
                        rep_cnt <= '0;
                        blk_cnt <= '0;
                        done_q  <= 1'b0;
                    end
                    BLANK: begin
                        rep_cnt <= '0;
                        done_q  <= 1'b0;
                        if (blk_cnt == BLK_TC) begin
                            state        <= RUN;
                            blk_cnt      <= '0;
                            RoutineReset <= run_reset(RoutineSel);
                        end else begin
                            blk_cnt <= blk_cnt + CNT_W'(1);
                        end
                    end
                    RUN: begin
                        if (go_next) begin
                            state       <= BLANK;
                            RoutineSel  <= next_sel;
                            SwitchPulse <= 1'b1;
                            rep_cnt     <= '0;
                            blk_cnt     <= '0;
                            done_q      <= 1'b0;
                        end else begin
                            RoutineReset <= run_reset(RoutineSel);
                            LedOut       <= sel_led;
                            Hex3         <= sel_hex3;
                            Hex2         <= sel_hex2;
                            Hex1         <= sel_hex1;
                            Hex0         <= sel_hex0;
                            done_q       <= sel_done;
                            if (done_edge) begin
                                rep_cnt <= rep_next;
                            end
                        end
                    end
                    default: begin
                        state <= IDLE;
                    end
                endcase
            end
        end
    end

endmodule
